// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU result path: operand field widths, saturation code, encoder states.
package tpu_pkg;

  localparam int unsigned EXP_W   = 4;
  localparam int unsigned MAN_W   = 3;
  localparam int unsigned MAX_EXP = 15;
  localparam int unsigned MAX_MAN = 7;

  // Exponent and mantissa both at full scale: the largest representable magnitude.
  localparam logic [EXP_W+MAN_W-1:0] SAT_CODE = 7'h7F;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    ABS,
    NORM,
    DONE
  } state_t;

endpackage

// File: rtl/tpu_abs32.sv
// Combinational two's-complement magnitude and sign extraction.
// The most negative input yields its magnitude as an unsigned value (0x80000000 -> 2^31).
module tpu_abs32 #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] value,
  output logic         sign,
  output logic [W-1:0] mag
);

  assign sign = value[W-1];
  assign mag  = sign ? -value : value;

endmodule

// File: rtl/tpu_result_encoder.sv
// Reads the MAC accumulator as two halves and re-encodes it as a sign/exp/mantissa byte.
// Define TPU_ENC_ROUND_EN to round half up on the last shifted-out bit instead of truncating.
module tpu_result_encoder #(
  parameter int unsigned ACC_W  = tpu_pkg::EXP_W * 8,
  parameter int unsigned HALF_W = ACC_W / 2,
  parameter int unsigned EXP_W  = tpu_pkg::EXP_W,
  parameter int unsigned MAN_W  = tpu_pkg::MAN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              out_HL,
  input  logic [HALF_W-1:0] acc_half,
  output logic [7:0]        result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              busy,
  output logic              overflow
);

  import tpu_pkg::*;

  state_t             state;
  state_t             state_nxt;
  logic [HALF_W-1:0]  lo;
  logic [HALF_W-1:0]  hi;
  logic               sign;
  logic [ACC_W-1:0]   mag;
  logic [EXP_W-1:0]   exp;
  logic               acc_sign;
  logic [ACC_W-1:0]   acc_mag;
  logic               mag_small;
  logic               exp_max;

  tpu_abs32 #(.W(ACC_W)) u_abs (
    .value ({hi, lo}),
    .sign  (acc_sign),
    .mag   (acc_mag)
  );

  assign mag_small = (mag <= ACC_W'(MAX_MAN));
  assign exp_max   = (exp == EXP_W'(MAX_EXP));

`ifdef TPU_ENC_ROUND_EN
  localparam logic [MAN_W-1:0] MAN_HALF = {1'b1, {(MAN_W-1){1'b0}}};
  logic             rbit;
  logic [MAN_W:0]   man_rnd;
  assign man_rnd = {1'b0, mag[MAN_W-1:0]} + {{MAN_W{1'b0}}, rbit};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RD_LO;
      RD_LO:   state_nxt = RD_HI;
      RD_HI:   state_nxt = ABS;
      ABS:     state_nxt = NORM;
      NORM:    if (mag_small || exp_max) state_nxt = DONE;
      DONE:    if (result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign out_HL       = (state == RD_HI);
  assign busy         = (state != IDLE);
  assign result_valid = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo       <= '0;
      hi       <= '0;
      sign     <= 1'b0;
      mag      <= '0;
      exp      <= '0;
      result   <= '0;
      overflow <= 1'b0;
`ifdef TPU_ENC_ROUND_EN
      rbit     <= 1'b0;
`endif
    end else begin
      unique case (state)
        RD_LO: lo <= acc_half;
        RD_HI: begin
          hi       <= acc_half;
          overflow <= 1'b0;
        end
        ABS: begin
          sign <= acc_sign;
          mag  <= acc_mag;
          exp  <= '0;
`ifdef TPU_ENC_ROUND_EN
          rbit <= 1'b0;
`endif
        end
        NORM: begin
          if (mag_small) begin
`ifdef TPU_ENC_ROUND_EN
            // A mantissa carry renormalises to 4 at the next exponent, or saturates at the top.
            if (man_rnd[MAN_W]) begin
              if (exp_max) begin
                result   <= {sign, SAT_CODE};
                overflow <= 1'b1;
              end else begin
                result <= {sign, exp + EXP_W'(1), MAN_HALF};
              end
            end else begin
              result <= {sign, exp, man_rnd[MAN_W-1:0]};
            end
`else
            result <= {sign, exp, mag[MAN_W-1:0]};
`endif
          end else if (exp_max) begin
            result   <= {sign, SAT_CODE};
            overflow <= 1'b1;
          end else begin
            mag  <= mag >> 1;
            exp  <= exp + EXP_W'(1);
`ifdef TPU_ENC_ROUND_EN
            rbit <= mag[0];
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
